pong_rally_ctrl: RTL
====================

Name: pong_rally_ctrl

Overview:
Game-level sequencer for the Pong ball datapath. Owns the ball block's active-low reset (ball_run) to hold, serve and stop the ball. Watches ball x position for misses past either paddle and keeps both players' scores. Runs the match from start-button press to game over; scores and game_over feed the score display.

Parameters:
LEFT_MISS_X, 90, ball x at or below this = left player missed (right scores)
RIGHT_MISS_X, 550, ball x at or above this = right player missed (left scores)
WRAP_X, 1000, x values >= this are treated as left underflow (10-bit wrap below 0)
WIN_SCORE, 7, score that ends the match (1..15)
SERVE_TICKS, 60, tick pulses the ball is held at centre before each serve (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  reset
start  input  1  player start button, asynchronous, level
tick  input  1  one-clk movement/frame strobe
ball_x_pos  input  10  current ball x from ball datapath
ball_y_pos  input  10  current ball y (reserved; ignored this revision)
ball_run  output  1  drives ball datapath reset_n; 0 = ball held at serve position
left_score  output  4  left player score
right_score  output  4  right player score
last_scorer  output  1  0 = left scored last, 1 = right
serving  output  1  high while in SERVE
game_over  output  1  high in GAME_OVER

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All outputs registered. Reset values: state IDLE, ball_run 0, left_score 0, right_score 0, last_scorer 0, serving 0, game_over 0, serve counter 0, start sync flops 0.
- start: 2-flop synchronizer, then rising-edge detect (start_pe, one clk wide). Held start produces only one start_pe.
- miss_left = (x <= LEFT_MISS_X) || (x >= WRAP_X). miss_right = (x >= RIGHT_MISS_X) && (x < WRAP_X). Parameters guarantee these are mutually exclusive.
- States and transitions:
- IDLE: ball_run 0. start_pe -> SERVE; serve counter cleared.
- SERVE: ball_run 0, serving 1. Counter increments on each tick. When tick arrives with count == SERVE_TICKS-1: -> PLAY, ball_run 1 on the same edge, counter cleared.
- PLAY: ball_run 1. On the edge where miss_left or miss_right is true: -> POINT, ball_run 0 on that edge. last_scorer set to 1 on miss_left, 0 on miss_right.
- POINT: exactly one clk. Scorer's score += 1, saturating at 15. If the new score == WIN_SCORE: -> GAME_OVER, game_over 1 on the same edge. Otherwise -> SERVE, serving 1.
- GAME_OVER: ball_run 0, scores frozen. start_pe -> SERVE with both scores cleared to 0, game_over 0, last_scorer unchanged.
- Latency: miss visible on ball_x_pos at edge N; ball_run low and state POINT after N. Score updated after N+1.
- start_pe in SERVE, PLAY or POINT is ignored. tick outside SERVE is ignored.
- Since ball_run is low in every state except PLAY, ball position is reset-valued outside PLAY. A miss condition outside PLAY is ignored.
- Reset mid-rally: immediate return to IDLE with scores cleared; ball_run 0 forces the ball datapath to reset.

Test Plan:
- Reset, start pulse, tick every 4 clk, SERVE_TICKS=3 -> serving high for exactly 3 ticks; ball_run rises on the edge of the 3rd tick; scores 0/0.
- PLAY, drive ball_x_pos 560 -> next edge ball_run 0; following edge left_score 1, last_scorer 0, state SERVE.
- PLAY, drive ball_x_pos 1023 (underflow wrap) -> right_score increments, last_scorer 1. Ball_x_pos 91 or 549 -> no score change.
- Left at 6, left misses scoring for right... then right reaches 7 via misses -> game_over 1, ball_run stays 0. Further misses and ticks do not change scores.
- GAME_OVER, hold start high 100 clk -> exactly one restart: scores 0/0, game_over 0, SERVE entered once. start toggled during PLAY -> no effect.
- Assert reset_n low mid-PLAY with scores 3/2 -> asynchronously ball_run 0, scores 0/0, state IDLE. A start pulse during reset is ignored.

Source files
------------

// File: rtl/pong_rally_ctrl.sv
// pong_rally_ctrl: match sequencer for the Pong ball datapath.
// Holds, serves and stops the ball through ball_run. Detects misses past either
// paddle from the ball x position and keeps both scores until a player wins.
//
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   start         - asynchronous level start button (synchronized internally)
//   tick          - one-clk frame strobe, paces the serve delay
//   ball_x_pos    - ball x position from the datapath
//   ball_y_pos    - ball y position (not used in this revision)
//   ball_run      - ball datapath active-low reset; 0 holds ball at serve position
//   left_score    - left player score
//   right_score   - right player score
//   last_scorer   - 0 = left scored last, 1 = right scored last
//   serving       - high while the ball is held before a serve
//   game_over     - high once a player reaches WIN_SCORE
module pong_rally_ctrl #(
  parameter int unsigned LEFT_MISS_X  = 90,
  parameter int unsigned RIGHT_MISS_X = 550,
  parameter int unsigned WRAP_X       = 1000,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_TICKS  = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tick,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  output logic       ball_run,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       last_scorer,
  output logic       serving,
  output logic       game_over
);

  localparam int unsigned X_W   = 10;
  localparam int unsigned SC_W  = 4;
  localparam int unsigned CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_GAME_OVER
  } state_e;

  state_e            state_q, state_d;
  logic              ball_run_q, ball_run_d;
  logic [SC_W-1:0]   left_q, left_d;
  logic [SC_W-1:0]   right_q, right_d;
  logic              last_q, last_d;
  logic              serving_q, serving_d;
  logic              game_over_q, game_over_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              start_s1_q, start_s2_q, start_s3_q;
  logic              start_pe;
  logic              miss_left, miss_right;
  logic [SC_W-1:0]   score_inc;

  // y position is reserved for a later revision
  logic unused_y;
  assign unused_y = ^ball_y_pos;

  // Two-flop synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
    end else begin
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
    end
  end

  assign start_pe = start_s2_q & ~start_s3_q;

  // x values at or above WRAP_X are the ball having underflowed past 0 on the left
  assign miss_left  = (ball_x_pos <= X_W'(LEFT_MISS_X)) || (ball_x_pos >= X_W'(WRAP_X));
  assign miss_right = (ball_x_pos >= X_W'(RIGHT_MISS_X)) && (ball_x_pos < X_W'(WRAP_X));

  // Saturating increment of whichever player scored the point being awarded
  always_comb begin
    score_inc = last_q ? right_q : left_q;
    if (score_inc != {SC_W{1'b1}}) begin
      score_inc = score_inc + SC_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ball_run_q  <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      last_q      <= 1'b0;
      serving_q   <= 1'b0;
      game_over_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ball_run_q  <= ball_run_d;
      left_q      <= left_d;
      right_q     <= right_d;
      last_q      <= last_d;
      serving_q   <= serving_d;
      game_over_q <= game_over_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ball_run_d  = ball_run_q;
    left_d      = left_q;
    right_d     = right_q;
    last_d      = last_q;
    serving_d   = serving_q;
    game_over_d = game_over_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        ball_run_d = 1'b0;
        if (start_pe) begin
          state_d   = ST_SERVE;
          serving_d = 1'b1;
          cnt_d     = '0;
        end
      end

      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
            state_d    = ST_PLAY;
            ball_run_d = 1'b1;
            serving_d  = 1'b0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (miss_left || miss_right) begin
          state_d    = ST_POINT;
          ball_run_d = 1'b0;
          last_d     = miss_left;
        end
      end

      ST_POINT: begin
        if (last_q) begin
          right_d = score_inc;
        end else begin
          left_d = score_inc;
        end
        if (score_inc == SC_W'(WIN_SCORE)) begin
          state_d     = ST_GAME_OVER;
          game_over_d = 1'b1;
        end else begin
          state_d   = ST_SERVE;
          serving_d = 1'b1;
          cnt_d     = '0;
        end
      end

      ST_GAME_OVER: begin
        ball_run_d = 1'b0;
        if (start_pe) begin
          state_d     = ST_SERVE;
          left_d      = '0;
          right_d     = '0;
          game_over_d = 1'b0;
          serving_d   = 1'b1;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        ball_run_d = 1'b0;
        serving_d  = 1'b0;
      end
    endcase
  end

  assign ball_run    = ball_run_q;
  assign left_score  = left_q;
  assign right_score = right_q;
  assign last_scorer = last_q;
  assign serving     = serving_q;
  assign game_over   = game_over_q;

endmodule
